pong_game_engine: RTL

- Game-logic stage directly upstream of the VGA renderer and the LED/SSD status logic in the top level.
- Owns ball motion, paddle collision, scoring and the game state machine.
- Consumes paddle positions from the button logic; produces ball coordinates, scores and the 2-bit game state.
- Advances one step per frame tick.

---
 rtl/pong_game_engine.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pong_game_engine.sv
// pong_game_engine: ball motion, paddle collision, scoring and game FSM, stepped once per frame tick.
// Optional PONG_SPEEDUP_EN: each paddle hit raises the horizontal speed by one, up to 8.
module pong_game_engine #(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BALL_SIZE   = 8,
   parameter int PADDLE_H    = 64,
   parameter int P1_X        = 24,
   parameter int P2_X        = 616,
   parameter int BALL_DX     = 2,
   parameter int BALL_DY     = 2,
   parameter int WIN_SCORE   = 10,
   parameter int SERVE_DELAY = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic [9:0] p1_pos,
   input  logic [9:0] p2_pos,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic [1:0] state,
   output logic       point
);
   localparam logic [1:0] QI = 2'b00, QGAME_1 = 2'b01, QGAME_2 = 2'b10, QDONE = 2'b11;
   localparam int SERVE_W = $clog2(SERVE_DELAY + 1);
   localparam logic [9:0] CX = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
   localparam logic [9:0] CY = 10'(SCREEN_H / 2 - BALL_SIZE / 2);
   localparam logic signed [10:0] BS   = 11'(BALL_SIZE);
   localparam logic signed [10:0] HALF = 11'(PADDLE_H / 2);
   localparam logic signed [10:0] DY   = 11'(BALL_DY);
   localparam logic signed [10:0] YMAX = 11'(SCREEN_H - BALL_SIZE);
   localparam logic signed [10:0] XMAX = 11'(SCREEN_W - BALL_SIZE);
   localparam logic signed [10:0] P1X  = 11'(P1_X);
   localparam logic signed [10:0] P2X  = 11'(P2_X);

   logic [SERVE_W-1:0] serve;
   logic               dy_up;
   logic [3:0]         dx;
   logic signed [10:0] bx, by, nx, ny, ny_c, lo1, hi1, lo2, hi2;
   logic               in_game, move, hit1, hit2, miss1, miss2, y_lo, y_hi;

   // Everything is widened to 11-bit signed so underflow and low paddle windows never wrap.
   always_comb begin
      bx      = {1'b0, ball_x};
      by      = {1'b0, ball_y};
      nx      = (state == QGAME_1) ? bx + {7'b0, dx} : bx - {7'b0, dx};
      ny      = dy_up ? by - DY : by + DY;
      y_lo    = ny < 0;
      y_hi    = ny > YMAX;
      ny_c    = y_lo ? 11'sd0 : y_hi ? YMAX : ny;
      lo1     = {1'b0, p1_pos} - HALF;
      hi1     = {1'b0, p1_pos} + HALF;
      lo2     = {1'b0, p2_pos} - HALF;
      hi2     = {1'b0, p2_pos} + HALF;
      hit1    = state == QGAME_2 && nx <= P1X && by + BS > lo1 && by < hi1;
      hit2    = state == QGAME_1 && nx + BS >= P2X && by + BS > lo2 && by < hi2;
      miss2   = state == QGAME_2 && !hit1 && nx <= 0;
      miss1   = state == QGAME_1 && !hit2 && nx >= XMAX;
      in_game = state == QGAME_1 || state == QGAME_2;
      move    = tick && start && in_game && serve == '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= QI;
         ball_x   <= CX;
         ball_y   <= CY;
         p1_score <= '0;
         p2_score <= '0;
         dy_up    <= 1'b0;
         serve    <= '0;
         point    <= 1'b0;
      end else begin
         point <= 1'b0;
         if (tick && state == QI && start) begin
            p1_score <= '0;
            p2_score <= '0;
            serve    <= SERVE_W'(SERVE_DELAY);
            state    <= QGAME_1;
         end else if (tick && !start && state != QI) begin
            state  <= QI;
            ball_x <= CX;
            ball_y <= CY;
         end else if (tick && in_game && serve != '0) begin
            serve <= serve - 1'b1;
         end else if (move) begin
            ball_y <= ny_c[9:0];
            dy_up  <= y_lo ? 1'b0 : y_hi ? 1'b1 : dy_up;
            if (hit1) begin
               ball_x <= 10'(P1_X);
               state  <= QGAME_1;
            end else if (hit2) begin
               ball_x <= 10'(P2_X - BALL_SIZE);
               state  <= QGAME_2;
            end else if (miss1 || miss2) begin
               point  <= 1'b1;
               ball_x <= CX;
               ball_y <= CY;
               serve  <= SERVE_W'(SERVE_DELAY);
               if (miss2) begin
                  p2_score <= p2_score + 4'd1;
                  if (p2_score + 4'd1 == 4'(WIN_SCORE)) state <= QDONE;
               end else begin
                  p1_score <= p1_score + 4'd1;
                  if (p1_score + 4'd1 == 4'(WIN_SCORE)) state <= QDONE;
               end
            end else begin
               ball_x <= nx[9:0];
            end
         end
      end
   end

`ifdef PONG_SPEEDUP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) dx <= 4'(BALL_DX);
      else if ((tick && (state == QI || !start)) || (move && (miss1 || miss2))) dx <= 4'(BALL_DX);
      else if (move && (hit1 || hit2)) dx <= (dx >= 4'd8) ? 4'd8 : dx + 4'd1;
   end
`else
   assign dx = 4'(BALL_DX);
`endif
endmodule
